// File: rtl/serial_subtr_seq.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell with a start/busy/done handshake.
module serial_subtr_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic             brw;
    logic             a_msb;
    logic             b_msb;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             nb_bit;

    function automatic logic cell_diff(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic cell_borrow(input logic x, input logic y, input logic c);
        return (~x & y) | (~(x ^ y) & c);
    endfunction

    assign d_bit  = cell_diff(sa[0], sb[0], brw);
    assign nb_bit = cell_borrow(sa[0], sb[0], brw);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            sd    <= '0;
            brw   <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        brw   <= bin;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    // Result bits enter at the MSB so the last bit lands in place.
                    sd  <= {d_bit, sd[WIDTH-1:1]};
                    sa  <= {1'b0, sa[WIDTH-1:1]};
                    sb  <= {1'b0, sb[WIDTH-1:1]};
                    brw <= nb_bit;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff  <= {d_bit, sd[WIDTH-1:1]};
                        bout  <= nb_bit;
                        ovf   <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtr_seq.md
Name: serial_subtr_seq

Overview:
- Bit-serial subtractor controller: computes A − B − BIN over WIDTH bits with one full-subtractor cell, one bit per clock, LSB first.
- Holds operand shift registers, the borrow flop, a bit counter and a start/busy/done handshake.
- Sits between a requester (ALU front-end or testbench) and the single-bit subtract datapath, trading area for latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high in RUN and DONE; new starts are ignored while high.
- done  output  1  one-cycle pulse, high during the DONE state.
- diff  output  WIDTH  result A − B − BIN mod 2^WIDTH; registered.
- bout  output  1  final borrow out (unsigned A < B + BIN).
- ovf  output  1  signed two's-complement overflow of the subtraction.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; internal shift registers, borrow flop and counter cleared. Reset mid-RUN aborts the operation and produces no done pulse.
- State IDLE:
  - start=1 at edge k: load sa=a, sb=b, brw=bin; latch a[WIDTH-1] and b[WIDTH-1] for ovf; cnt=0; go to RUN.
  - start=0: stay in IDLE.
- State RUN, each edge: compute the cell from sa[0], sb[0], brw:
  - d = sa[0]^sb[0]^brw
  - nb = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&brw)
  - Shift d into the MSB of internal result register sd (shift right).
  - Shift sa and sb right by 1; brw ← nb; cnt ← cnt+1.
- RUN exit, edge where cnt==WIDTH-1 (edge k+WIDTH):
  - diff ← final sd including this bit; bout ← nb.
  - ovf ← (a_msb ^ b_msb) & (a_msb ^ final d).
  - Go to DONE.
- State DONE: done=1 for exactly one cycle; next edge goes to IDLE.
- Latency: start accepted at edge k; done high in the cycle after edge k+WIDTH; next start accepted no earlier than edge k+WIDTH+2.
- start while busy=1 (RUN or DONE) is ignored with no side effects. Operand changes after the accepting edge have no effect.
- diff, bout and ovf change only at the RUN-exit edge or on reset. They hold their values through IDLE until the next completion; a new start does not clear them.
- Counter width is clog2(WIDTH) and must not wrap before exit. No illegal state is reachable; any undefined encoding returns to IDLE.
- busy is a registered state decode, glitch-free. done is never high in two consecutive cycles.

Test Plan:
- Basic: WIDTH=8, a=0x5A, b=0x33, bin=0, start pulse -> done exactly 9 cycles after the accepting edge; diff=0x27, bout=0, ovf=0; busy high for 9 cycles.
- Unsigned underflow: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0.
- Signed overflow: a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- Borrow-in chain: a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0, ovf=0. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- Handshake:
  - Hold start high continuously and change a/b every cycle -> each operation uses only the operands sampled in IDLE.
  - Successive accepts are WIDTH+2 cycles apart; done pulses are one cycle wide.
  - Outputs hold between operations.
- Reset mid-run: assert rst asynchronously 4 cycles into RUN -> all outputs 0 immediately, no done pulse. After release, start with a=0xC3, b=0x41 -> diff=0x82, bout=0, ovf=0.
